// File: rtl/param_interrupt_controller.sv
// 8259-style interrupt controller: edge/level requests, rotating priority, masking,
// EOI/rotate commands and a two-strobe acknowledge that yields a vector byte.
module param_interrupt_controller #(
    parameter int N_IRQ = 8,
    parameter int ID_W  = $clog2(N_IRQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [15:0]      wr_data,
    input  logic             inta,
    output logic             int_out,
    output logic [7:0]       vec_out,
    output logic             vec_valid,
    output logic [N_IRQ-1:0] irr_out,
    output logic [N_IRQ-1:0] isr_out,
    output logic [N_IRQ-1:0] imr_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK1 = 2'd1,
        ACK2 = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [N_IRQ-1:0] irq_prev_r, irr_r, isr_r, imr_r;
    logic [ID_W-1:0]  rot_r, rot_s, ack_id_r;
    logic [3:0]       mode_r;
    logic [7:0]       vbase_r;
    logic             spurious_r;

    logic             cand_valid_s, ns_valid_s;
    logic [ID_W-1:0]  cand_id_s, ns_id_s, l_id_s;
    logic [N_IRQ-1:0] isr_eff_s, isr_set_s, isr_clr_s, irr_clr_s;
    logic             first_ack_s, aeoi_s, l_ok_s;
    logic [2:0]       eoi_cmd_s;

    function automatic logic [N_IRQ-1:0] onehot(input logic [ID_W-1:0] id);
        onehot = N_IRQ'(1'b1) << id;
    endfunction

    // Walk channels from highest priority (rot+1) downward to find the candidate and
    // the highest-priority in-service channel.
    always_comb begin
        logic [ID_W-1:0] id_v;
        logic            blocked_v;
        logic            hit_v;
        cand_valid_s = 1'b0;
        cand_id_s    = {ID_W{1'b0}};
        ns_valid_s   = 1'b0;
        ns_id_s      = {ID_W{1'b0}};
        blocked_v    = 1'b0;
        hit_v        = 1'b0;
        id_v         = {ID_W{1'b0}};
        // With special mask, in-service channels that are masked do not block others.
        isr_eff_s    = mode_r[3] ? (isr_r & ~imr_r) : isr_r;
        for (int k = 0; k < N_IRQ; k++) begin
            id_v         = ID_W'((int'(rot_r) + 1 + k) % N_IRQ);
            hit_v        = !ns_valid_s && isr_r[id_v];
            ns_id_s      = hit_v ? id_v : ns_id_s;
            ns_valid_s   = ns_valid_s | isr_r[id_v];
            hit_v        = !cand_valid_s && !blocked_v && !isr_eff_s[id_v] &&
                           irr_r[id_v] && !imr_r[id_v];
            cand_id_s    = hit_v ? id_v : cand_id_s;
            cand_valid_s = cand_valid_s | hit_v;
            blocked_v    = blocked_v | isr_eff_s[id_v];
        end
    end

    // Per-cycle set/clear masks and rotation from acknowledge, auto-EOI and commands.
    always_comb begin
        first_ack_s = (state_r == IDLE) && inta;
        aeoi_s      = (state_r == ACK2) && mode_r[1] && !spurious_r;
        l_ok_s      = int'(wr_data[3:0]) < N_IRQ;
        l_id_s      = wr_data[ID_W-1:0];
        eoi_cmd_s   = (wr_en && (wr_addr == 2'd1)) ? wr_data[7:5] : 3'b000;
        isr_set_s   = (first_ack_s && cand_valid_s) ? onehot(cand_id_s) : {N_IRQ{1'b0}};
        irr_clr_s   = (first_ack_s && cand_valid_s && !mode_r[0]) ?
                      onehot(cand_id_s) : {N_IRQ{1'b0}};
        isr_clr_s   = aeoi_s ? onehot(ack_id_r) : {N_IRQ{1'b0}};
        rot_s       = (aeoi_s && mode_r[2]) ? ack_id_r : rot_r;
        case (eoi_cmd_s)
            3'b001: isr_clr_s = isr_clr_s | (ns_valid_s ? onehot(ns_id_s) : {N_IRQ{1'b0}});
            3'b011: isr_clr_s = isr_clr_s | (l_ok_s ? onehot(l_id_s) : {N_IRQ{1'b0}});
            3'b101: begin
                isr_clr_s = isr_clr_s | (ns_valid_s ? onehot(ns_id_s) : {N_IRQ{1'b0}});
                rot_s     = ns_valid_s ? ns_id_s : rot_s;
            end
            3'b111: begin
                isr_clr_s = isr_clr_s | (l_ok_s ? onehot(l_id_s) : {N_IRQ{1'b0}});
                rot_s     = l_ok_s ? l_id_s : rot_s;
            end
            3'b110:  rot_s = l_ok_s ? l_id_s : rot_s;
            default: isr_clr_s = isr_clr_s;
        endcase
    end

    // Acknowledge sequence next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = inta ? ACK1 : IDLE;
            ACK1:    state_s = inta ? ACK2 : ACK1;
            ACK2:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request, service, configuration and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_prev_r <= {N_IRQ{1'b0}};
            irr_r      <= {N_IRQ{1'b0}};
            isr_r      <= {N_IRQ{1'b0}};
            imr_r      <= {N_IRQ{1'b1}};
            rot_r      <= ID_W'(N_IRQ - 1);
            mode_r     <= 4'd0;
            vbase_r    <= 8'd0;
            ack_id_r   <= {ID_W{1'b0}};
            spurious_r <= 1'b0;
            int_out    <= 1'b0;
            vec_out    <= 8'd0;
            vec_valid  <= 1'b0;
        end else begin
            irq_prev_r <= irq_in;
            irr_r      <= mode_r[0] ? irq_in
                                    : ((irr_r & ~irr_clr_s) | (irq_in & ~irq_prev_r));
            // A set from the first acknowledge wins over a clear of the same bit.
            isr_r      <= (isr_r & ~isr_clr_s) | isr_set_s;
            rot_r      <= rot_s;
            if (wr_en) begin
                case (wr_addr)
                    2'd0:    imr_r   <= wr_data[N_IRQ-1:0];
                    2'd2:    mode_r  <= wr_data[3:0];
                    2'd3:    vbase_r <= wr_data[7:0];
                    default: vbase_r <= vbase_r;
                endcase
            end else begin
                vbase_r <= vbase_r;
            end
            if (first_ack_s) begin
                ack_id_r   <= cand_valid_s ? cand_id_s : ID_W'(N_IRQ - 1);
                spurious_r <= !cand_valid_s;
            end else begin
                ack_id_r   <= ack_id_r;
            end
            int_out   <= (state_r == IDLE) && !inta && cand_valid_s;
            vec_valid <= (state_r == ACK1) && inta;
            if ((state_r == ACK1) && inta) begin
                vec_out <= vbase_r + 8'(ack_id_r);
            end else begin
                vec_out <= vec_out;
            end
        end
    end

    assign irr_out = irr_r;
    assign isr_out = isr_r;
    assign imr_out = imr_r;

endmodule
